// File: rtl/fp_addsub_pkg.sv
// Shared definitions for the pipelined floating-point adder/subtractor.
// Word format is {sign, exp, man}; exp==0 encodes zero and exp all-ones is an ordinary finite exponent.
package fp_addsub_pkg;

    localparam int EXP_W_DEF = 4;
    localparam int MAN_W_DEF = 7;

    // Field positions for the default format.
    localparam int MAN_LSB  = 0;
    localparam int EXP_LSB  = MAN_W_DEF;
    localparam int SIGN_POS = EXP_W_DEF + MAN_W_DEF;

    function automatic int exp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    typedef struct packed {
        logic                 sign;
        logic [EXP_W_DEF-1:0] exp;
        logic [MAN_W_DEF:0]   sig;
    } unpacked_t;

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter; an all-zero input reports N.
module fp_lzc #(
    parameter  int N  = 8,
    localparam int CW = $clog2(N + 1)
) (
    input  logic [N-1:0]  v,
    output logic [CW-1:0] cnt
);

    logic found;

    always_comb begin
        cnt   = CW'(N);
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                cnt   = CW'(N - 1 - i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Three-stage floating-point add/subtract: unpack/align, add/sub, normalise/pack.
// All stages shift together when the output is empty or being consumed; results are truncated.
module fp_addsub_pipe
    import fp_addsub_pkg::*;
#(
    parameter  int EXP_W = EXP_W_DEF,
    parameter  int MAN_W = MAN_W_DEF,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         op_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] z,
    output logic         ovf,
    output logic         unf
);

    localparam int SW = MAN_W + 1;
    localparam int CW = $clog2(SW + 1);
    localparam int XW = EXP_W + CW;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SW-1:0]    sig;
    } op_t;

    function automatic op_t unpack(input logic [W-1:0] x, input logic flip);
        op_t o;
        o.sign = x[W-1] ^ flip;
        o.exp  = x[W-2:MAN_W];
        o.sig  = (o.exp != '0) ? {1'b1, x[MAN_W-1:0]} : '0;
        return o;
    endfunction

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Stage 1: larger magnitude becomes L; S is aligned to L's exponent.
    op_t              opa, opb, opl, ops;
    logic [EXP_W-1:0] d;
    logic [SW-1:0]    s_aligned;

    always_comb begin
        opa = unpack(a, 1'b0);
        opb = unpack(b, op_sub);
        if (a[W-2:0] >= b[W-2:0]) begin
            opl = opa;
            ops = opb;
        end else begin
            opl = opb;
            ops = opa;
        end
        d         = opl.exp - ops.exp;
        s_aligned = (32'(d) >= SW) ? '0 : (ops.sig >> d);
    end

    logic             s1_valid, s1_sign, s1_sub;
    logic [EXP_W-1:0] s1_exp;
    logic [SW-1:0]    s1_sig_l, s1_sig_s;

    logic             s2_valid, s2_sign;
    logic [EXP_W-1:0] s2_exp;
    logic [SW:0]      s2_sum;

    // Stage 3: renormalise the sum and apply saturation / flush.
    logic [CW-1:0] lzc;
    logic [W-1:0]  z_n;
    logic          ovf_n, unf_n;

    fp_lzc #(.N(SW)) u_lzc (
        .v   (s2_sum[SW-1:0]),
        .cnt (lzc)
    );

    always_comb begin
        z_n   = '0;
        ovf_n = 1'b0;
        unf_n = 1'b0;
        if (s2_sum != '0) begin
            if (s2_sum[SW]) begin
                if (s2_exp == EXP_ONES) begin
                    z_n   = {s2_sign, {(W-1){1'b1}}};
                    ovf_n = 1'b1;
                end else begin
                    z_n = {s2_sign, s2_exp + 1'b1, s2_sum[SW-1:1]};
                end
            end else if (XW'(lzc) >= XW'(s2_exp)) begin
                unf_n = 1'b1;
            end else begin
                z_n = {s2_sign, s2_exp - EXP_W'(lzc), MAN_W'(s2_sum[SW-1:0] << lzc)};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_sign   <= 1'b0;
            s1_sub    <= 1'b0;
            s1_exp    <= '0;
            s1_sig_l  <= '0;
            s1_sig_s  <= '0;
            s2_valid  <= 1'b0;
            s2_sign   <= 1'b0;
            s2_exp    <= '0;
            s2_sum    <= '0;
            out_valid <= 1'b0;
            z         <= '0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
        end else if (adv) begin
            s1_valid  <= in_valid;
            s1_sign   <= opl.sign;
            s1_sub    <= opl.sign ^ ops.sign;
            s1_exp    <= opl.exp;
            s1_sig_l  <= opl.sig;
            s1_sig_s  <= s_aligned;
            // L >= S in magnitude, so the difference never goes negative.
            s2_valid  <= s1_valid;
            s2_sign   <= s1_sign;
            s2_exp    <= s1_exp;
            s2_sum    <= s1_sub ? ({1'b0, s1_sig_l} - {1'b0, s1_sig_s})
                                : ({1'b0, s1_sig_l} + {1'b0, s1_sig_s});
            out_valid <= s2_valid;
            z         <= z_n;
            ovf       <= ovf_n;
            unf       <= unf_n;
        end
    end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe (default format, bias 7): vector table run
// isolated and back-to-back, then backpressure and mid-flight reset sequences.
module tb_fp_addsub_pipe;

    localparam int W  = 12;
    localparam int NV = 20;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, op_sub;
    logic         out_valid, out_ready, ovf, unf;
    logic [W-1:0] a, b, z;

    always #5 clk = ~clk;

    fp_addsub_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .ovf       (ovf),
        .unf       (unf)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         op;
        logic [W-1:0] z;
        logic         ovf;
        logic         unf;
    } vec_t;

    vec_t vecs[NV];

    int           total = 0;
    int           bad   = 0;
    int           cyc   = 0;
    int           n_out = 0;
    int           n0;
    int           acc_t;
    bit           chk_lat;
    logic [W+1:0] cur_exp;
    logic [W+1:0] exp_e;
    logic [W+1:0] exp_q[$];
    int           acc_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard: record expectations on accept, compare on each consumed result.
    always @(negedge clk) begin
        cyc++;
        if (!rst && in_valid && in_ready) begin
            exp_q.push_back(cur_exp);
            acc_q.push_back(cyc);
        end
        if (!rst && out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 32'(z), 32'hFFFF_FFFF);
            end else begin
                exp_e = exp_q.pop_front();
                acc_t = acc_q.pop_front();
                chk("z", 32'(z), 32'(exp_e[W+1:2]));
                chk("ovf", 32'(ovf), 32'(exp_e[1]));
                chk("unf", 32'(unf), 32'(exp_e[0]));
                if (chk_lat) chk("latency", 32'(cyc - acc_t), 32'd3);
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the pair.
    task automatic send(input vec_t v);
        bit got;
        a        = v.a;
        b        = v.b;
        op_sub   = v.op;
        cur_exp  = {v.z, v.ovf, v.unf};
        in_valid = 1'b1;
        got      = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!got) chk("accept_timeout", 32'(got), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 30; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        op_sub    = 1'b0;
        out_ready = 1'b1;
        cur_exp   = '0;
        chk_lat   = 1'b1;

        vecs = '{
            '{12'h380, 12'h380, 1'b0, 12'h400, 1'b0, 1'b0},
            '{12'h3C0, 12'h3C0, 1'b0, 12'h440, 1'b0, 1'b0},
            '{12'h400, 12'h3C0, 1'b1, 12'h300, 1'b0, 1'b0},
            '{12'h380, 12'h380, 1'b1, 12'h000, 1'b0, 1'b0},
            '{12'h3C0, 12'h400, 1'b1, 12'hB00, 1'b0, 1'b0},
            '{12'h7FF, 12'h7FF, 1'b0, 12'h7FF, 1'b1, 1'b0},
            '{12'h0C0, 12'h080, 1'b1, 12'h000, 1'b0, 1'b1},
            '{12'h380, 12'hB80, 1'b0, 12'h000, 1'b0, 1'b0},
            '{12'h000, 12'h380, 1'b0, 12'h380, 1'b0, 1'b0},
            '{12'h005, 12'h003, 1'b0, 12'h000, 1'b0, 1'b0},
            '{12'h500, 12'h100, 1'b0, 12'h500, 1'b0, 1'b0},
            '{12'h480, 12'h100, 1'b0, 12'h481, 1'b0, 1'b0},
            '{12'h380, 12'h300, 1'b1, 12'h300, 1'b0, 1'b0},
            '{12'hBC0, 12'hBC0, 1'b0, 12'hC40, 1'b0, 1'b0},
            '{12'h380, 12'h381, 1'b0, 12'h400, 1'b0, 1'b0},
            '{12'hFFF, 12'hFFF, 1'b0, 12'hFFF, 1'b1, 1'b0},
            '{12'h780, 12'h000, 1'b1, 12'h780, 1'b0, 1'b0},
            '{12'h800, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0},
            '{12'h8C0, 12'h880, 1'b1, 12'h000, 1'b0, 1'b1},
            '{12'h7C0, 12'hFC0, 1'b1, 12'h7FF, 1'b1, 1'b0}
        };

        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_z", 32'(z), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_unf", 32'(unf), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // One operation at a time.
        for (int i = 0; i < NV; i++) begin
            send(vecs[i]);
            in_valid = 1'b0;
            drain();
        end

        // Back-to-back at full throughput.
        for (int i = 0; i < NV; i++) send(vecs[i]);
        in_valid = 1'b0;
        drain();

        // Backpressure: three fill the pipe, the fourth waits.
        chk_lat   = 1'b0;
        out_ready = 1'b0;
        n0        = n_out;
        send(vecs[0]);
        send(vecs[1]);
        send(vecs[2]);
        a        = vecs[3].a;
        b        = vecs[3].b;
        op_sub   = vecs[3].op;
        cur_exp  = {vecs[3].z, vecs[3].ovf, vecs[3].unf};
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_z_hold", 32'(z), 32'(vecs[0].z));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(vecs[3]);
        in_valid = 1'b0;
        drain();
        chk("bp_count", 32'(n_out - n0), 32'd4);

        // Reset with two operations in flight.
        chk_lat = 1'b1;
        send(vecs[1]);
        send(vecs[2]);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        exp_q.delete();
        acc_q.delete();
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_z", 32'(z), 32'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("post_rst_valid", 32'(out_valid), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
